serial_fa_adder_ctrl: RTL and testbench



---
 rtl/serial_fa_adder_ctrl_if.sv | 26 ++
 rtl/serial_fa_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_fa_adder_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_fa_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder: operands and start in, status and result out.
interface serial_fa_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Requester side: issues operations and observes results
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    // Adder side: accepts operations and produces results
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_fa_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one decoder-based full-adder cell, LSB first, one bit per clock.

// Full adder built from a 3-to-8 minterm decoder; sum and carry are OR-planes of minterms.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    logic [7:0] minterm;

    // One-hot decode of {a,b,c}
    assign minterm = 8'(8'd1 << {a, b, c});
    assign sum     = minterm[1] | minterm[2] | minterm[4] | minterm[7];
    assign carry   = minterm[3] | minterm[5] | minterm[6] | minterm[7];
endmodule

module serial_fa_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_fa_adder_ctrl_if.slave bus
);
    localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST_BIT = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             c_r_q;
    logic             c_msb_q;
    logic [CNT_W-1:0] cnt_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_c;

    // The only arithmetic on operand bits: current LSBs plus running carry
    serial_fa_cell u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (c_r_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    // Sequencer: latch on start, shift WIDTH bits through the cell, publish result in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_r_q    <= 1'b0;
            c_msb_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        c_r_q   <= bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
                    c_r_q    <= fa_c;
                    busy_q   <= 1'b1;
                    if (cnt_q == CNT_W'(LAST_BIT)) begin
                        // c_r_q still holds the carry into the MSB on this edge
                        c_msb_q <= c_r_q;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    sum_q   <= sum_sh_q;
                    cout_q  <= c_r_q;
                    ovf_q   <= c_msb_q ^ c_r_q;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_fa_adder_ctrl.sv
// Directed and random checks of the bit-serial adder controller.
module tb_serial_fa_adder_ctrl;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   done_pulses;

    serial_fa_adder_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_fa_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and done-pulse counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait up to a bound for done; returns edges waited
    task automatic wait_done(input int start_lat, output int lat);
        lat = start_lat;
        while (bus_if.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One full operation with latency and result checks
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int lat;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.cin   = ci;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.a     = 8'($urandom);
        bus_if.b     = 8'($urandom);
        bus_if.cin   = 1'($urandom);
        chk({tag, " busy_after_start"}, 32'(bus_if.busy), 32'd1);
        wait_done(0, lat);
        chk({tag, " latency"}, 32'(lat), 32'd8);
        chk({tag, " busy_in_done"}, 32'(bus_if.busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, " done_drop"}, 32'(bus_if.done), 32'd0);
        chk({tag, " busy_drop"}, 32'(bus_if.busy), 32'd0);
        chk({tag, " result"}, 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'({eo, ec, es}));
    endtask

    initial begin
        int lat;
        int p0;
        int t [3];
        logic [7:0] ra, rb, rs;
        logic       rc, rco, rov;
        logic [8:0] full;

        checks = 0; errors = 0; cyc = 0; done_pulses = 0;
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.a = '0; bus_if.b = '0; bus_if.cin = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus_if.busy), 32'd0);
        chk("reset done", 32'(bus_if.done), 32'd0);
        chk("reset result", 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed sums
        p0 = done_pulses;
        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "35+4A");
        repeat (3) @(posedge clk);
        chk("35+4A single_done", 32'(done_pulses - p0), 32'd1);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "FF+01");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7F+01");
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "00+00+1");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF+FF+1");

        // Start during SHIFT is ignored; previous result held meanwhile
        p0 = done_pulses;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.a = 8'h12; bus_if.b = 8'h34; bus_if.cin = 1'b0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus_if.start = 1'b1; bus_if.a = 8'hAA; bus_if.b = 8'h55; bus_if.cin = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        chk("ign held_sum", 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'h1FF);
        wait_done(3, lat);
        chk("ign latency", 32'(lat), 32'd8);
        @(posedge clk); #1;
        chk("ign result", 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'h046);
        repeat (12) @(posedge clk);
        #1;
        chk("ign done_count", 32'(done_pulses - p0), 32'd1);
        chk("ign idle", 32'(bus_if.busy), 32'd0);

        // Reset mid-operation aborts without done
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.a = 8'h55; bus_if.b = 8'h55; bus_if.cin = 1'b0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 32'(bus_if.busy), 32'd0);
        chk("abort done", 32'(bus_if.done), 32'd0);
        chk("abort result", 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'd0);
        @(negedge clk); rst = 1'b0;
        p0 = done_pulses;
        repeat (12) @(posedge clk);
        #1;
        chk("abort no_done", 32'(done_pulses - p0), 32'd0);
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "10+20");

        // rst wins over simultaneous start
        @(negedge clk);
        rst = 1'b1; bus_if.start = 1'b1; bus_if.a = 8'h01; bus_if.b = 8'h01;
        @(posedge clk); #1;
        rst = 1'b0; bus_if.start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start busy", 32'(bus_if.busy), 32'd0);
        chk("rst_start result", 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'd0);

        // Start held high: back-to-back ops, done every 10 cycles
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.a = 8'h35; bus_if.b = 8'h4A; bus_if.cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_done(0, lat);
            chk("b2b done_seen", 32'(bus_if.done), 32'd1);
            t[k] = cyc;
            @(posedge clk); #1;
            chk("b2b result", 32'({bus_if.ovf, bus_if.cout, bus_if.sum}), 32'h07F);
        end
        bus_if.start = 1'b0;
        chk("b2b spacing01", 32'(t[1] - t[0]), 32'd10);
        chk("b2b spacing12", 32'(t[2] - t[1]), 32'd10);
        repeat (12) @(posedge clk);

        // Random operands against a+b+cin and sign-rule overflow
        for (int n = 0; n < 200; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            full = 9'(ra) + 9'(rb) + 9'(rc);
            rs   = full[7:0];
            rco  = full[8];
            rov  = (ra[7] == rb[7]) && (rs[7] != ra[7]);
            do_op(ra, rb, rc, rs, rco, rov, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
